// File: rtl/core_seq.sv
// Instruction sequencer/controller for the alureg datapath: fetches opcode and immediate bytes and issues alureg strobes.
// Latency: MOV/ALU 4 cycles, MVI 6 cycles, HLT 2 cycles to HALT, plus one cycle per memory wait cycle.
// Backpressure: mem_rd is held with a stable mem_addr until mem_ack; an unbounded wait simply stalls the sequence.
//
// Ports:
//   clk, rst            rising-edge clock; synchronous active-high reset
//   run                 level; allows leaving IDLE and fetching the next instruction
//   mem_rd/mem_addr     program read request (address = pc), held until mem_ack
//   mem_ack/mem_data    read acknowledge and data, valid in the same cycle
//   bus_d               registered byte presented to the alureg data input
//   ienb                alureg enables: code latch, data latch, register read, register write
//   halted, badop       HALT indicator; one-cycle pulse on an unsupported opcode
//   icount              retired-instruction count (wraps)
module core_seq #(
    parameter int DATASIZE = 8,
    parameter int ADDRSIZE = 16,
    parameter int IENBSIZE = 6,
    parameter int IENB_COD = 0,
    parameter int IENB_DAT = 1,
    parameter int IENB_PC_ = 2,
    parameter int IENB_PD_ = 3,
    parameter int IENB_RRD = 4,
    parameter int IENB_RWR = 5,
    parameter logic [ADDRSIZE-1:0] RSTADDR = 16'h0000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                run,
    input  logic                mem_ack,
    input  logic [DATASIZE-1:0] mem_data,
    output logic                mem_rd,
    output logic [ADDRSIZE-1:0] mem_addr,
    output logic [DATASIZE-1:0] bus_d,
    output logic [IENBSIZE-1:0] ienb,
    output logic                halted,
    output logic                badop,
    output logic [15:0]         icount
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_CODE,
        S_FETCHD,
        S_DATA,
        S_EXRD,
        S_EXWR,
        S_HALT
    } state_t;

    state_t              state_q, state_d;
    logic [ADDRSIZE-1:0] pc_q, pc_d;
    logic [DATASIZE-1:0] bus_d_q, bus_d_d;
    logic [15:0]         icount_q, icount_d;

    logic [IENBSIZE-1:0] ienb_c;
    logic                mem_rd_c;
    logic                halted_c;
    logic                badop_c;

    // Opcode fields of the byte latched in bus_d during CODE.
    logic [7:0] op;
    logic       is_mvi, is_mov, is_alu, is_hlt;

    assign op = bus_d_q[7:0];

    // Any operand field of 110 addresses memory (M), which this datapath cannot reach.
    assign is_mvi = (op[7:6] == 2'b00) && (op[2:0] == 3'b110) && (op[5:3] != 3'b110);
    assign is_mov = (op[7:6] == 2'b01) && (op[5:3] != 3'b110) && (op[2:0] != 3'b110);
    assign is_alu = (op[7:6] == 2'b10) && (op[2:0] != 3'b110);
    assign is_hlt = (op == 8'h76);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            pc_q     <= RSTADDR;
            bus_d_q  <= '0;
            icount_q <= 16'h0000;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            bus_d_q  <= bus_d_d;
            icount_q <= icount_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        bus_d_d  = bus_d_q;
        icount_d = icount_q;
        ienb_c   = '0;
        mem_rd_c = 1'b0;
        halted_c = 1'b0;
        badop_c  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (run) begin
                    state_d = S_FETCH;
                end
            end

            S_FETCH, S_FETCHD: begin
                mem_rd_c = 1'b1;
                if (mem_ack) begin
                    bus_d_d = mem_data;
                    state_d = (state_q == S_FETCH) ? S_CODE : S_DATA;
                end
            end

            S_CODE: begin
                ienb_c[IENB_COD] = 1'b1;
                pc_d             = pc_q + ADDRSIZE'(1);
                if (is_mvi) begin
                    state_d = S_FETCHD;
                end else if (is_mov || is_alu) begin
                    state_d = S_EXRD;
                end else if (is_hlt) begin
                    // HLT retires on entry to HALT; it never passes through EXWR.
                    icount_d = icount_q + 16'h0001;
                    state_d  = S_HALT;
                end else begin
                    badop_c = 1'b1;
                    state_d = run ? S_FETCH : S_IDLE;
                end
            end

            S_DATA: begin
                ienb_c[IENB_DAT] = 1'b1;
                pc_d             = pc_q + ADDRSIZE'(1);
                state_d          = S_EXRD;
            end

            S_EXRD: begin
                ienb_c[IENB_RRD] = 1'b1;
                state_d          = S_EXWR;
            end

            S_EXWR: begin
                // Read stays asserted so the datapath source is still driven during write.
                ienb_c[IENB_RRD] = 1'b1;
                ienb_c[IENB_RWR] = 1'b1;
                icount_d         = icount_q + 16'h0001;
                state_d          = run ? S_FETCH : S_IDLE;
            end

            S_HALT: begin
                halted_c = 1'b1;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // PC is sequenced internally; the datapath PC controls stay idle.
        ienb_c[IENB_PC_] = 1'b0;
        ienb_c[IENB_PD_] = 1'b0;
    end

    assign mem_rd   = mem_rd_c;
    assign mem_addr = pc_q;
    assign bus_d    = bus_d_q;
    assign ienb     = ienb_c;
    assign halted   = halted_c;
    assign badop    = badop_c;
    assign icount   = icount_q;

endmodule

// File: doc/core_seq.md
Name: core_seq

Overview:
- Instruction sequencer and controller for the 8085-style alureg datapath.
- Fetches opcode and immediate bytes from program memory through a simple request/acknowledge port.
- Presents each fetched byte on the datapath input bus and generates the alureg enable strobes (code latch, data latch, register read, register write) in the order the datapath expects.
- Supports MVI r, MOV r,r, ALU r and HLT. It replaces the hand-driven strobes used in unit benches and forms the control half of the core.

Parameters:
- DATASIZE, 8, data bus and opcode width.
- ADDRSIZE, 16, program address width.
- IENBSIZE, 6, width of the alureg enable vector.
- IENB_COD, 0, enable-vector index for the code (instruction) latch.
- IENB_DAT, 1, enable-vector index for the data (temp) latch.
- IENB_PC_, 2, enable-vector index for PC increment; always driven 0 by this block.
- IENB_PD_, 3, enable-vector index for PC load; always driven 0 by this block.
- IENB_RRD, 4, enable-vector index for register read.
- IENB_RWR, 5, enable-vector index for register write.
- RSTADDR, 16'h0000, PC value after reset.

Ports:
- clk  input  1  system clock; rising-edge.
- rst  input  1  reset; synchronous, active-high.
- run  input  1  level; sequencer may leave IDLE and continue fetching while high.
- mem_ack  input  1  memory acknowledge; mem_data is valid in this cycle.
- mem_data  input  DATASIZE  program memory read data.
- mem_rd  output  1  memory read request, held until mem_ack.
- mem_addr  output  ADDRSIZE  read address, equal to the PC.
- bus_d  output  DATASIZE  registered byte driven to the alureg data input.
- ienb  output  IENBSIZE  alureg enable strobes.
- halted  output  1  high while in HALT.
- badop  output  1  one-cycle pulse on an unsupported opcode.
- icount  output  16  count of retired instructions; wraps at 16'hFFFF.

Behaviour:
- Reset (synchronous, rst=1 at a clock edge):
  - state=IDLE, pc=RSTADDR, bus_d=0, ienb=0, mem_rd=0, halted=0, badop=0, icount=0.
  - rst overrides every state, including mid-fetch and HALT.
  - An outstanding request is abandoned; a late mem_ack is ignored.
- Outputs that never change: ienb[IENB_PC_] and ienb[IENB_PD_] are always 0.
- States:
  - IDLE: all strobes 0. Go to FETCH when run=1.
  - FETCH: mem_rd=1, mem_addr=pc. On mem_ack=1, capture mem_data into bus_d and go to CODE. Otherwise stay; wait is unbounded.
  - CODE: ienb[IENB_COD]=1 for exactly one cycle; pc<=pc+1. Decode bus_d as follows:
    - 00rrr110 with rrr!=110 (MVI): go to FETCHD.
    - 01dddsss with ddd!=110 and sss!=110 (MOV): go to EXRD.
    - 10ooosss with sss!=110 (ALU): go to EXRD.
    - 8'h76 (HLT): go to HALT.
    - Anything else, including M operands: pulse badop, count nothing, treat as NOP, and go to FETCH if run=1, else IDLE.
  - FETCHD: same as FETCH; the captured byte goes to bus_d. On mem_ack, go to DATA.
  - DATA: ienb[IENB_DAT]=1 for one cycle; pc<=pc+1. Go to EXRD.
  - EXRD: ienb[IENB_RRD]=1 only. Go to EXWR.
  - EXWR: ienb[IENB_RRD]=1 and ienb[IENB_RWR]=1; icount<=icount+1. Go to FETCH if run=1, else IDLE.
  - HALT: halted=1, mem_rd=0, all strobes 0. icount is incremented once on entry. Exit only by rst.
- Hold and sequencing rules:
  - bus_d is stable from capture until the next capture.
  - mem_addr is stable while mem_rd=1.
- Timing with zero-wait memory (mem_ack in the first FETCH cycle):
  - MOV and ALU take 4 cycles.
  - MVI takes 6 cycles.
  - HLT takes 2 cycles to reach HALT.
  - Each memory wait cycle adds 1 cycle.
- run dropping mid-instruction does not abort; the instruction completes, then the block goes to IDLE.
- pc wraps from 16'hFFFF to 16'h0000 without any flag.
- Only one ienb bit other than RRD/RWR is high in any cycle.

Test Plan:
- Reset: hold rst for 2 cycles with run=1 → ienb=0, mem_rd=0, mem_addr=16'h0000, icount=0; FETCH starts on the cycle after rst falls.
- Program 3E AA 47 AF 4F 76 with zero-wait memory, driving a real alureg:
  - ienb sequence: COD, DAT, RRD, RRD+RWR, then (COD, RRD, RRD+RWR) ×3, then COD.
  - Final registers: A=00, B=AA, C=00.
  - End state: halted=1, icount=5, mem_addr=16'h0006.
- Memory wait: mem_ack delayed 3 cycles on every fetch → MOV B,A takes 7 cycles; mem_addr and mem_rd held stable through the wait; COD still a single-cycle pulse.
- Bad opcode 8'h7E (MOV A,M) → badop pulses for one cycle in CODE; no RRD/RWR; icount unchanged; next fetch at pc+1.
- Drop run during EXRD of MOV → EXWR still issued, icount increments, state goes to IDLE; raising run resumes at the next pc.
- Wrap and reset: RSTADDR=16'hFFFF with MVI at FFFF → immediate fetched from 16'h0000; asserting rst in FETCHD → IDLE, pc=FFFF, and a late mem_ack has no effect.
